// File: rtl/counter_checker.sv
// Receive-side sequence checker for a counter stream.
// Acquires lock, flags deviations, keeps a saturating error tally.
module counter_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int COUNT_FROM   = 0,
  parameter longint COUNT_TO = (64'd1 << DATA_WIDTH) - 1,
  parameter int STEP         = 1,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr_err,
  output logic                  locked,
  output logic                  err,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic [DATA_WIDTH-1:0] expected
);

  localparam longint MAXV = (64'd1 << DATA_WIDTH) - 1;
  localparam longint TOV  = (COUNT_TO > MAXV) ? MAXV : COUNT_TO;
  localparam int     MW   = $clog2(LOCK_COUNT + 1);
  localparam int     NW   = $clog2(UNLOCK_COUNT + 1);

  localparam logic [DATA_WIDTH:0]   TO_W   = TOV[DATA_WIDTH:0];
  localparam logic [DATA_WIDTH:0]   STEP_W = STEP[DATA_WIDTH:0];
  localparam logic [DATA_WIDTH-1:0] FROM_W = COUNT_FROM[DATA_WIDTH-1:0];
  localparam logic [MW-1:0]         LOCK_W = LOCK_COUNT[MW-1:0];
  localparam logic [NW-1:0]         UNL_W  = UNLOCK_COUNT[NW-1:0];

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [MW-1:0]         match_q, match_d;
  logic [NW-1:0]         miss_q, miss_d;
  logic                  err_q, err_d;
  logic [ERR_WIDTH-1:0]  cnt_q, cnt_d;

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] nxt;
  logic                  hit;
  logic [MW-1:0]         match_inc;
  logic [NW-1:0]         miss_inc;

  // Sum is one bit wider so a step past the top can't alias low.
  always_comb begin
    sum = {1'b0, din} + STEP_W;
    if (sum > TO_W) nxt = FROM_W;
    else            nxt = sum[DATA_WIDTH-1:0];
  end

  assign hit       = (din == exp_q);
  assign match_inc = match_q + MW'(1);
  assign miss_inc  = miss_q + NW'(1);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (en) begin
      exp_d = nxt;
      unique case (state_q)
        HUNT: begin
          match_d = MW'(1);
          miss_d  = '0;
          if (LOCK_COUNT == 1) state_d = LOCKED;
          else                 state_d = VERIFY;
        end
        VERIFY: begin
          if (hit) begin
            match_d = match_inc;
            if (match_inc == LOCK_W) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = MW'(1);
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (cnt_q != '1) cnt_d = cnt_q + ERR_WIDTH'(1);
            if (miss_inc == UNL_W) begin
              state_d = HUNT;
              match_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clr_err) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q   <= FROM_W;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_count = cnt_q;
  assign expected  = exp_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: acquisition, wrap, skip,
// lock loss, gaps, clear, reset and tally saturation.
module tb_counter_checker;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr;
  logic [7:0] din;
  logic       locked, err;
  logic [15:0] cnt;
  logic [7:0] expv;

  logic       rst2, en2, clr2;
  logic [7:0] din2;
  logic       locked2, err2;
  logic [1:0] cnt2;
  logic [7:0] exp2;

  int n_cmp = 0;
  int n_bad = 0;

  counter_checker #(
    .DATA_WIDTH(8), .COUNT_FROM(20), .COUNT_TO(255), .STEP(1),
    .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr_err(clr),
    .locked(locked), .err(err), .err_count(cnt), .expected(expv)
  );

  counter_checker #(
    .DATA_WIDTH(8), .COUNT_FROM(20), .COUNT_TO(255), .STEP(1),
    .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_WIDTH(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .din(din2), .clr_err(clr2),
    .locked(locked2), .err(err2), .err_count(cnt2), .expected(exp2)
  );

  task automatic put(input logic [7:0] d, input logic c);
    @(negedge clk);
    en = 1'b1; din = d; clr = c;
    @(posedge clk);
    #1;
    en = 1'b0; clr = 1'b0;
  endtask

  task automatic put2(input logic [7:0] d);
    @(negedge clk);
    en2 = 1'b1; din2 = d;
    @(posedge clk);
    #1;
    en2 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++; $display("FAIL reset_locked got %0b want 0", locked);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err got %0b want 0", err);
    end
    n_cmp++;
    if (cnt !== 16'd0) begin
      n_bad++; $display("FAIL reset_cnt got %0d want 0", cnt);
    end
    n_cmp++;
    if (expv !== 8'd20) begin
      n_bad++; $display("FAIL reset_exp got %0d want 20", expv);
    end
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_acquire();
    for (int v = 20; v <= 23; v++) begin
      put(8'(v), 1'b0);
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++; $display("FAIL acq_err v=%0d got %0b want 0", v, err);
      end
      n_cmp++;
      if (locked !== (v == 23)) begin
        n_bad++;
        $display("FAIL acq_locked v=%0d got %0b want %0b",
                 v, locked, (v == 23));
      end
    end
    n_cmp++;
    if (expv !== 8'd24) begin
      n_bad++; $display("FAIL acq_exp got %0d want 24", expv);
    end
  endtask

  task automatic test_wrap();
    int errs;
    errs = 0;
    for (int v = 24; v <= 253; v++) begin
      put(8'(v), 1'b0);
      if (err !== 1'b0) errs++;
    end
    n_cmp++;
    if (errs != 0) begin
      n_bad++; $display("FAIL run_to_253 errs got %0d want 0", errs);
    end
    put(8'd254, 1'b0);
    put(8'd255, 1'b0);
    n_cmp++;
    if (expv !== 8'd20) begin
      n_bad++; $display("FAIL wrap_exp got %0d want 20", expv);
    end
    put(8'd20, 1'b0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL wrap_err got %0b want 0", err);
    end
    put(8'd21, 1'b0);
    n_cmp++;
    if (locked !== 1'b1 || err !== 1'b0 || cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL wrap_state got l=%0b e=%0b c=%0d want 1 0 0",
               locked, err, cnt);
    end
  endtask

  task automatic test_skip();
    int errs;
    errs = 0;
    for (int v = 22; v <= 51; v++) begin
      put(8'(v), 1'b0);
      if (err !== 1'b0) errs++;
    end
    n_cmp++;
    if (errs != 0) begin
      n_bad++; $display("FAIL skip_pre errs got %0d want 0", errs);
    end
    put(8'd53, 1'b0);
    n_cmp++;
    if (err !== 1'b1 || cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL skip_err got e=%0b c=%0d want 1 1", err, cnt);
    end
    n_cmp++;
    if (expv !== 8'd54) begin
      n_bad++; $display("FAIL skip_exp got %0d want 54", expv);
    end
    put(8'd54, 1'b0);
    n_cmp++;
    if (err !== 1'b0 || locked !== 1'b1 || cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL skip_post got e=%0b l=%0b c=%0d want 0 1 1",
               err, locked, cnt);
    end
  endtask

  task automatic test_lock_loss();
    for (int i = 0; i < 3; i++) begin
      put(8'd0, 1'b0);
      n_cmp++;
      if (err !== 1'b1 || cnt !== 16'(2 + i)) begin
        n_bad++;
        $display("FAIL loss_err i=%0d got e=%0b c=%0d want 1 %0d",
                 i, err, cnt, 2 + i);
      end
      n_cmp++;
      if (locked !== (i < 2)) begin
        n_bad++;
        $display("FAIL loss_locked i=%0d got %0b want %0b",
                 i, locked, (i < 2));
      end
    end
    for (int v = 100; v <= 103; v++) begin
      put(8'(v), 1'b0);
      n_cmp++;
      if (locked !== (v == 103) || err !== 1'b0) begin
        n_bad++;
        $display("FAIL relock v=%0d got l=%0b e=%0b want %0b 0",
                 v, locked, err, (v == 103));
      end
    end
    n_cmp++;
    if (cnt !== 16'd4 || expv !== 8'd104) begin
      n_bad++;
      $display("FAIL relock_state got c=%0d x=%0d want 4 104",
               cnt, expv);
    end
  endtask

  task automatic test_gap();
    int errs;
    errs = 0;
    for (int v = 104; v <= 255; v++) begin
      put(8'(v), 1'b0);
      if (err !== 1'b0) errs++;
    end
    for (int v = 20; v <= 30; v++) begin
      put(8'(v), 1'b0);
      if (err !== 1'b0) errs++;
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      if (err !== 1'b0) errs++;
    end
    n_cmp++;
    if (errs != 0 || expv !== 8'd31) begin
      n_bad++;
      $display("FAIL gap_idle got errs=%0d x=%0d want 0 31", errs, expv);
    end
    put(8'd31, 1'b0);
    n_cmp++;
    if (err !== 1'b0 || locked !== 1'b1 || cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL gap_resume got e=%0b l=%0b c=%0d want 0 1 4",
               err, locked, cnt);
    end
  endtask

  task automatic test_clear();
    put(8'd99, 1'b1);
    n_cmp++;
    if (err !== 1'b1 || cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_mismatch got e=%0b c=%0d want 1 0", err, cnt);
    end
    n_cmp++;
    if (locked !== 1'b1 || expv !== 8'd100) begin
      n_bad++;
      $display("FAIL clr_state got l=%0b x=%0d want 1 100", locked, expv);
    end
    put(8'd100, 1'b0);
    n_cmp++;
    if (err !== 1'b0 || cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_after got e=%0b c=%0d want 0 0", err, cnt);
    end
  endtask

  task automatic test_rst_mid();
    put(8'd7, 1'b0);
    n_cmp++;
    if (cnt !== 16'd1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_rst got c=%0d l=%0b want 1 1", cnt, locked);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (locked !== 1'b0 || cnt !== 16'd0 || expv !== 8'd20) begin
      n_bad++;
      $display("FAIL mid_rst got l=%0b c=%0d x=%0d want 0 0 20",
               locked, cnt, expv);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_saturate();
    for (int v = 20; v <= 23; v++) put2(8'(v));
    n_cmp++;
    if (locked2 !== 1'b1) begin
      n_bad++; $display("FAIL sat_lock got %0b want 1", locked2);
    end
    for (int i = 0; i < 5; i++) begin
      put2(8'd0);
      n_cmp++;
      if (err2 !== 1'b1 || cnt2 !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin
        n_bad++;
        $display("FAIL sat_err i=%0d got e=%0b c=%0d want 1 %0d",
                 i, err2, cnt2, (i < 3) ? i + 1 : 3);
      end
      put2(8'd1);
      n_cmp++;
      if (err2 !== 1'b0 || locked2 !== 1'b1) begin
        n_bad++;
        $display("FAIL sat_good i=%0d got e=%0b l=%0b want 0 1",
                 i, err2, locked2);
      end
    end
    n_cmp++;
    if (cnt2 !== 2'd3) begin
      n_bad++; $display("FAIL sat_final got %0d want 3", cnt2);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; din = '0;
    rst2 = 1'b0; en2 = 1'b0; clr2 = 1'b0; din2 = '0;
    test_reset();
    test_acquire();
    test_wrap();
    test_skip();
    test_lock_loss();
    test_gap();
    test_clear();
    test_rst_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
